// File: rtl/piso_frame_pkg.sv
// Shared types and line levels for the framed parallel-to-serial transmitter.
package piso_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage : piso_frame_pkg

// File: rtl/shift_reg_piso.sv
// Parallel-load, shift-right register; LSB is presented as the serial bit.
module shift_reg_piso #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // clear dominates load, load dominates shift
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = d_i;
    end else if (shift_i) begin
      q_d = {1'b0, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign ser_o = q_q[0];

endmodule : shift_reg_piso

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
module piso_frame_tx
  import piso_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] i,
  input  logic             load,
  input  logic             clear,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             shift_en;
  logic             ser_bit;

  // ready is decoded from state only, so accept has no loop through outputs
  assign accept   = load & ready & ~clear;
  assign shift_en = (state_q == DATA) & ~clear;

  shift_reg_piso #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk_i   (clk),
    .rst_ni  (reset_b),
    .clear_i (clear),
    .load_i  (accept),
    .shift_i (shift_en),
    .d_i     (i),
    .ser_o   (ser_bit)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: state_d = DATA;
        DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (accept) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    sout  = IDLE_LEVEL;
    ready = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        sout  = IDLE_LEVEL;
        ready = 1'b1;
      end
      START: begin
        sout  = START_LEVEL;
        ready = 1'b0;
        busy  = 1'b1;
      end
      DATA: begin
        sout  = ser_bit;
        ready = 1'b0;
        busy  = 1'b1;
      end
      STOP: begin
        sout  = STOP_LEVEL;
        ready = 1'b1;
        done  = 1'b1;
      end
      default: begin
        sout  = IDLE_LEVEL;
        ready = 1'b1;
      end
    endcase
  end

endmodule : piso_frame_tx

// File: tb/tb_piso_frame_tx.sv
// Directed vector bench for piso_frame_tx with WIDTH=4.
module tb_piso_frame_tx;

  logic       clk;
  logic       reset_b;
  logic [3:0] i;
  logic       load;
  logic       clear;
  logic       ready;
  logic       sout;
  logic       busy;
  logic       done;

  int unsigned checks;
  int unsigned failures;

  typedef struct {
    logic       rst_b;
    logic       ld;
    logic       clr;
    logic [3:0] din;
    logic [3:0] exp;   // {sout, ready, busy, done} after the edge
    int         tag;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] O_IDLE = 4'b1100;
  localparam logic [3:0] O_STRT = 4'b0010;
  localparam logic [3:0] O_D0   = 4'b0010;
  localparam logic [3:0] O_D1   = 4'b1010;
  localparam logic [3:0] O_STOP = 4'b1101;

  piso_frame_tx #(
    .WIDTH (4)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .i       (i),
    .load    (load),
    .clear   (clear),
    .ready   (ready),
    .sout    (sout),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic l, input logic c,
                     input logic [3:0] d, input logic [3:0] e, input int t);
    vec_t v;
    v.rst_b = r; v.ld = l; v.clr = c; v.din = d; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {sout, ready, busy, done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s {sout,ready,busy,done} got=%b expected=%b at t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_b  = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    i        = 4'b0000;

    // reset held, then idle
    add(0, 0, 0, 4'h0, O_IDLE, 1);
    add(0, 1, 0, 4'hF, O_IDLE, 2);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 4'h0, O_IDLE, 10 + k);
    // single frame 1010 -> 0,0,1,0,1,1
    add(1, 1, 0, 4'b1010, O_STRT, 20);
    add(1, 0, 0, 4'h0, O_D0,   21);
    add(1, 0, 0, 4'h0, O_D1,   22);
    add(1, 0, 0, 4'h0, O_D0,   23);
    add(1, 0, 0, 4'h0, O_D1,   24);
    add(1, 0, 0, 4'h0, O_STOP, 25);
    add(1, 0, 0, 4'h0, O_IDLE, 26);
    // back-to-back 1100 then 0011 loaded in STOP
    add(1, 1, 0, 4'b1100, O_STRT, 30);
    add(1, 1, 0, 4'b1100, O_D0,   31);
    add(1, 1, 0, 4'b1100, O_D0,   32);
    add(1, 1, 0, 4'b1100, O_D1,   33);
    add(1, 1, 0, 4'b1100, O_D1,   34);
    add(1, 1, 0, 4'b1100, O_STOP, 35);
    add(1, 1, 0, 4'b0011, O_STRT, 36);
    add(1, 0, 0, 4'h0, O_D1,   37);
    add(1, 0, 0, 4'h0, O_D1,   38);
    add(1, 0, 0, 4'h0, O_D0,   39);
    add(1, 0, 0, 4'h0, O_D0,   40);
    add(1, 0, 0, 4'h0, O_STOP, 41);
    add(1, 0, 0, 4'h0, O_IDLE, 42);
    // load during DATA is ignored
    add(1, 1, 0, 4'b1001, O_STRT, 50);
    add(1, 0, 0, 4'h0,    O_D1,   51);
    add(1, 1, 0, 4'b0110, O_D0,   52);
    add(1, 1, 0, 4'b0110, O_D0,   53);
    add(1, 0, 0, 4'h0,    O_D1,   54);
    add(1, 0, 0, 4'h0,    O_STOP, 55);
    add(1, 0, 0, 4'h0,    O_IDLE, 56);
    // clear mid-frame, then clear+load in IDLE
    add(1, 1, 0, 4'b1010, O_STRT, 60);
    add(1, 0, 0, 4'h0,    O_D0,   61);
    add(1, 0, 0, 4'h0,    O_D1,   62);
    add(1, 0, 1, 4'h0,    O_IDLE, 63);
    add(1, 0, 0, 4'h0,    O_IDLE, 64);
    add(1, 1, 1, 4'hF,    O_IDLE, 65);
    add(1, 0, 0, 4'h0,    O_IDLE, 66);
    // clear+load in STOP also wins
    add(1, 1, 0, 4'b0000, O_STRT, 70);
    add(1, 0, 0, 4'h0,    O_D0,   71);
    add(1, 0, 0, 4'h0,    O_D0,   72);
    add(1, 0, 0, 4'h0,    O_D0,   73);
    add(1, 0, 0, 4'h0,    O_D0,   74);
    add(1, 0, 0, 4'h0,    O_STOP, 75);
    add(1, 1, 1, 4'hA,    O_IDLE, 76);
    add(1, 0, 0, 4'h0,    O_IDLE, 77);

    foreach (vecs[n]) begin
      reset_b = vecs[n].rst_b;
      load    = vecs[n].ld;
      clear   = vecs[n].clr;
      i       = vecs[n].din;
      step();
      check($sformatf("vec%0d", vecs[n].tag), vecs[n].exp);
    end

    // async reset between edges during DATA, while sout=0
    load = 1'b1; i = 4'b0101; step(); check("ar_start", O_STRT);
    load = 1'b0; i = 4'b0000; step(); check("ar_d0", O_D1);
    step(); check("ar_d1", O_D0);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("ar_immediate", O_IDLE);
    step(); check("ar_held", O_IDLE);
    @(negedge clk);
    reset_b = 1'b1;
    load = 1'b1; i = 4'b0101;
    step(); check("ar_post_start", O_STRT);
    load = 1'b0; i = 4'b0000;
    step(); check("ar_post_d0", O_D1);
    step(); check("ar_post_d1", O_D0);
    step(); check("ar_post_d2", O_D1);
    step(); check("ar_post_d3", O_D0);
    step(); check("ar_post_stop", O_STOP);
    step(); check("ar_post_idle", O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_piso_frame_tx
